// File: rtl/miter_result_monitor_pkg.sv
// miter_mon_pkg: shared state encoding and helpers for the miter result monitor
package miter_mon_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} mon_state_e;
  localparam logic [63:0] ERR_SAT = '1;
  function automatic logic masked_diff(input logic gold, input logic gate, input logic care);
    return (gold ^ gate) & care;
  endfunction
endpackage

// File: rtl/miter_result_monitor_cmp_stage.sv
// miter_cmp_stage: registered compare stage holding one accepted sample and its mismatch flag
module miter_cmp_stage #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             load,
  input  logic [CNT_W-1:0] load_idx,
  input  logic [WIDTH-1:0] load_gold,
  input  logic [WIDTH-1:0] load_gate,
  input  logic [WIDTH-1:0] load_diff,
  output logic             valid,
  output logic [CNT_W-1:0] idx,
  output logic [WIDTH-1:0] gold,
  output logic [WIDTH-1:0] gate,
  output logic [WIDTH-1:0] diff,
  output logic             mismatch
);
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid <= 1'b0;
      idx   <= '0;
      gold  <= '0;
      gate  <= '0;
      diff  <= '0;
    end else begin
      valid <= load;
      if (load) begin
        idx  <= load_idx;
        gold <= load_gold;
        gate <= load_gate;
        diff <= load_diff;
      end
    end
  end
  assign mismatch = valid && |diff;
endmodule

// File: rtl/miter_result_monitor.sv
// miter_result_monitor: scores a bounded run of gold/gate miter samples with first-fail capture
module miter_result_monitor
  import miter_mon_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = 32,
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] run_len,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] gold,
  input  logic [WIDTH-1:0] gate,
  input  logic [WIDTH-1:0] care,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             fail_seen,
  output logic [CNT_W-1:0] fail_idx,
  output logic [WIDTH-1:0] fail_gold,
  output logic [WIDTH-1:0] fail_gate,
  output logic [WIDTH-1:0] fail_diff
);
  mon_state_e state, state_n;
  logic [CNT_W-1:0] len, cnt, s_idx;
  logic [WIDTH-1:0] diff, s_gold, s_gate, s_diff;
  logic start_ok, acc, s_valid, s_mis;
  assign start_ok = start && (state == IDLE || state == DONE);
  assign acc      = state == RUN && in_valid && cnt < len;
  for (genvar i = 0; i < WIDTH; i++) begin : g_diff
    assign diff[i] = masked_diff(gold[i], gate[i], care[i]);
  end
  miter_cmp_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_cmp (
    .clk      (clk),
    .rst      (rst),
    .flush    (start_ok),
    .load     (acc),
    .load_idx (cnt),
    .load_gold(gold),
    .load_gate(gate),
    .load_diff(diff),
    .valid    (s_valid),
    .idx      (s_idx),
    .gold     (s_gold),
    .gate     (s_gate),
    .diff     (s_diff),
    .mismatch (s_mis)
  );
  // The last sample enters the stage on the RUN->DRAIN edge and retires on the next one.
  always_comb begin
    state_n = state;
    if (start_ok) state_n = (run_len == '0) ? DONE : RUN;
    else if (acc && cnt == len - CNT_W'(1)) state_n = DRAIN;
    else if (state == DRAIN) state_n = DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      len       <= '0;
      cnt       <= '0;
      err_cnt   <= '0;
      fail_seen <= 1'b0;
      fail_idx  <= '0;
      fail_gold <= '0;
      fail_gate <= '0;
      fail_diff <= '0;
    end else begin
      state <= state_n;
      if (start_ok) begin
        len       <= run_len;
        cnt       <= '0;
        err_cnt   <= '0;
        fail_seen <= 1'b0;
        fail_idx  <= '0;
        fail_gold <= '0;
        fail_gate <= '0;
        fail_diff <= '0;
      end else begin
        if (acc) cnt <= cnt + CNT_W'(1);
        if (s_mis) begin
          if (err_cnt != ERR_SAT[ERR_W-1:0]) err_cnt <= err_cnt + ERR_W'(1);
          if (!fail_seen) begin
            fail_seen <= 1'b1;
            fail_idx  <= s_idx;
            fail_gold <= s_gold;
            fail_gate <= s_gate;
            fail_diff <= s_diff;
          end
        end
      end
    end
  end
  assign busy = state == RUN;
  assign done = state == DONE;
  assign pass = done && err_cnt == '0;
  a_drained: assert property (@(posedge clk) disable iff (rst) state == DONE |-> !s_valid);
endmodule

// File: tb/tb_miter_result_monitor.sv
// tb_miter_result_monitor: randomized runs scored against a queue-based model of the run rules
module tb_miter_result_monitor;
  localparam int WIDTH = 4;
  localparam int CNT_W = 8;
  localparam int ERR_W = 2;
  localparam int SAT = (1 << ERR_W) - 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic [CNT_W-1:0] run_len = '0;
  logic [WIDTH-1:0] gold = '0, gate = '0, care = '0;
  logic busy, done, pass, fail_seen;
  logic [ERR_W-1:0] err_cnt;
  logic [CNT_W-1:0] fail_idx;
  logic [WIDTH-1:0] fail_gold, fail_gate, fail_diff;
  logic [WIDTH-1:0] q_gold[$], q_gate[$], q_care[$];
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  miter_result_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .run_len(run_len), .in_valid(in_valid),
    .gold(gold), .gate(gate), .care(care), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .fail_seen(fail_seen), .fail_idx(fail_idx),
    .fail_gold(fail_gold), .fail_gate(fail_gate), .fail_diff(fail_diff)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_err"}, err_cnt, 0);
    check({tag, "_fseen"}, fail_seen, 0);
    check({tag, "_fidx"}, fail_idx, 0);
    check({tag, "_fgold"}, fail_gold, 0);
    check({tag, "_fgate"}, fail_gate, 0);
    check({tag, "_fdiff"}, fail_diff, 0);
  endtask
  // kind: 0 clean, 1 random, 2 all don't-care, 3 all mismatch, 4 directed first-fail
  task automatic do_run(input int len, input int kind, input int gap_pct, input bit poke);
    int n, k, errs, first;
    logic [WIDTH-1:0] g, t, c;
    q_gold.delete();
    q_gate.delete();
    q_care.delete();
    start = 1'b1;
    run_len = CNT_W'(len);
    in_valid = 1'b1;
    gold = WIDTH'($urandom);
    gate = ~gold;
    care = '1;
    tick();
    start = 1'b0;
    if (len == 0) begin
      in_valid = 1'b0;
      check("zero_done", done, 1);
      check("zero_pass", pass, 1);
      check("zero_busy", busy, 0);
      check("zero_err", err_cnt, 0);
      return;
    end
    check("busy_rise", busy, 1);
    check("busy_done", done, 0);
    n = 0;
    while (n < len) begin
      in_valid = $urandom_range(99) >= gap_pct;
      k = q_gold.size();
      g = WIDTH'($urandom);
      t = WIDTH'($urandom);
      c = WIDTH'($urandom);
      case (kind)
        0: t = g;
        2: begin g = '0; t = '1; c = '0; end
        3: begin t = ~g; c = '1; end
        4: begin
          c = '1;
          g = (k == 2) ? 4'hA : (k == 4) ? 4'h5 : 4'h3;
          t = (k == 2) ? 4'hB : (k == 4) ? 4'h6 : 4'h3;
        end
        default: ;
      endcase
      gold = g;
      gate = t;
      care = c;
      start = poke && n == 1;
      run_len = CNT_W'($urandom_range(1, 20));
      if (in_valid) begin
        q_gold.push_back(g);
        q_gate.push_back(t);
        q_care.push_back(c);
        n++;
      end
      tick();
    end
    start = 1'b0;
    in_valid = 1'b1;
    gold = WIDTH'($urandom);
    gate = ~gold;
    care = '1;
    check("drain_done", done, 0);
    check("drain_busy", busy, 0);
    tick();
    errs = 0;
    first = -1;
    foreach (q_gold[i]) if (((q_gold[i] ^ q_gate[i]) & q_care[i]) != 0) begin
      errs++;
      if (first < 0) first = i;
    end
    check("done", done, 1);
    check("done_busy", busy, 0);
    check("err_cnt", err_cnt, errs > SAT ? SAT : errs);
    check("pass", pass, errs == 0);
    check("fail_seen", fail_seen, first >= 0);
    check("fail_idx", fail_idx, first >= 0 ? first : 0);
    check("fail_gold", fail_gold, first >= 0 ? q_gold[first] : 0);
    check("fail_gate", fail_gate, first >= 0 ? q_gate[first] : 0);
    check("fail_diff", fail_diff, first >= 0 ? (q_gold[first] ^ q_gate[first]) & q_care[first] : 0);
    tick();
    in_valid = 1'b0;
    check("hold_done", done, 1);
    check("hold_err", err_cnt, errs > SAT ? SAT : errs);
  endtask
  initial begin
    tick();
    tick();
    rst = 1'b0;
    check_idle("reset");
    do_run(8, 0, 0, 0);
    do_run(5, 4, 0, 0);
    check("ff_idx2", fail_idx, 2);
    check("ff_diff1", fail_diff, 4'h1);
    do_run(6, 2, 0, 0);
    do_run(6, 3, 0, 0);
    do_run(0, 0, 0, 0);
    do_run(7, 1, 40, 1);
    for (int r = 0; r < 30; r++)
      do_run($urandom_range(0, 12), $urandom_range(0, 3), $urandom_range(0, 50), $urandom_range(0, 1));
    start = 1'b1;
    run_len = 8'd8;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      gold = 4'h5;
      gate = (i == 1) ? 4'h4 : 4'h5;
      care = '1;
      tick();
    end
    check("pre_rst_err", err_cnt, 1);
    check("pre_rst_fidx", fail_idx, 1);
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    gate = 4'hA;
    tick();
    check_idle("mid_rst");
    rst = 1'b0;
    in_valid = 1'b0;
    do_run(8, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
